hamming_product_decoder: RTL and testbench

//  Receive-side decoder for the 111-bit product-code word {data[63:0], h_enc[11:0], v_enc[11:0], d_enc1[11:0], d_enc2[10:0]}.
//  SEC-decodes the four Hamming-protected parity words, then recomputes the row (H), column (V) and anti-diagonal (D)

---
 rtl/hamming_dec_pkg.sv | 29 ++
 rtl/hamming_sec_dec.sv | 56 +++++
 rtl/hamming_product_decoder.sv | 192 +++++++++++++++++++
 tb/tb_hamming_product_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_dec_pkg.sv
// Shared definitions for the Hamming product-code decoder: codeword field
// offsets, FSM state encoding and the anti-diagonal index helper.
// The 15 anti-diagonal parity bits are split across two SEC words:
// d_enc1 carries diagonals 7..0, d_enc2 carries diagonals 14..8.
`timescale 1ns/1ps
package hamming_dec_pkg;

  localparam int CW_W     = 111;
  localparam int DATA_W   = 64;
  localparam int DATA_LSB = 47;
  localparam int H_LSB    = 35;
  localparam int V_LSB    = 23;
  localparam int D1_LSB   = 11;
  localparam int D2_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PDEC = 3'd1,
    ST_SYND = 3'd2,
    ST_CORR = 3'd3,
    ST_OUT  = 3'd4
  } dec_state_t;

  // Anti-diagonal of data bit b (row b/8, column b%8): 14 - (row + col).
  function automatic logic [3:0] diag_idx(input logic [5:0] b);
    return 4'd14 - ({1'b0, b[5:3]} + {1'b0, b[2:0]});
  endfunction

endpackage

// File: rtl/hamming_sec_dec.sv
// Combinational single-error-correcting Hamming decoder. Bit i of the code
// word is position i+1; parity sits at positions 1,2,4,8 and data fills the
// remaining positions in ascending order.
`timescale 1ns/1ps
module hamming_sec_dec #(
  parameter int N = 12,
  parameter int K = 8
) (
  input  logic [N-1:0] i_code,
  output logic [K-1:0] o_data,
  output logic         o_corrected,
  output logic         o_bad_syn
);

  logic [3:0] w_syn;

  // Index of the code bit that holds data bit j.
  function automatic int data_slot(input int j);
    int seen;
    int slot;
    seen = 0;
    slot = 0;
    for (int i = 0; i < N; i++) begin
      if (((i + 1) & i) != 0) begin
        if (seen == j) begin
          slot = i;
        end else begin
          slot = slot;
        end
        seen = seen + 1;
      end else begin
        seen = seen;
      end
    end
    return slot;
  endfunction

  // Syndrome is the XOR of the positions of all set bits.
  always_comb begin
    w_syn = 4'd0;
    for (int i = 0; i < N; i++) begin
      w_syn = w_syn ^ (i_code[i] ? 4'(i + 1) : 4'd0);
    end
  end

  // Classify the syndrome and extract data, flipping the addressed position.
  always_comb begin
    o_corrected = (w_syn != 4'd0) && (32'(w_syn) <= 32'(N));
    o_bad_syn   = (32'(w_syn) > 32'(N));
    o_data      = '0;
    for (int j = 0; j < K; j++) begin
      o_data[j] = i_code[data_slot(j)] ^ (w_syn == 4'(data_slot(j) + 1));
    end
  end

endmodule

// File: rtl/hamming_product_decoder.sv
// Receive-side product-code decoder: SEC-decodes the H/V/D parity words,
// recomputes row, column and anti-diagonal parity over the 8x8 data array
// and corrects a single data-bit error. One word in flight at a time.
// Optional build macro HAMMING_DEC_STATS_EN adds the CNT_W parameter and the
// saturating corr_cnt/uncorr_cnt statistics outputs.
// Latency: out_valid is high in the fourth cycle after the accept cycle
// (IDLE, PDEC, SYND, CORR, OUT -> at most one word every five cycles).
`timescale 1ns/1ps
module hamming_product_decoder
  import hamming_dec_pkg::*;
`ifdef HAMMING_DEC_STATS_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   codeword_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_corr_data,
  output logic              err_corr_par,
  output logic              err_uncorr,
  output logic [5:0]        err_pos
`ifdef HAMMING_DEC_STATS_EN
  ,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
`endif
);

  dec_state_t        r_state;
  logic [CW_W-1:0]   r_cw;
  logic [DATA_W-1:0] r_data;
  logic [7:0]        r_h, r_v, r_hs, r_vs;
  logic [14:0]       r_d, r_ds;
  logic              r_par_corr, r_par_bad;
  logic              r_in_ready, r_out_valid;
  logic [DATA_W-1:0] r_data_out;
  logic              r_err_corr_data, r_err_corr_par, r_err_uncorr;
  logic [5:0]        r_err_pos;

  logic [7:0]  w_h_dec, w_v_dec, w_d1_dec;
  logic [6:0]  w_d2_dec;
  logic [3:0]  w_fix, w_bad;
  logic [7:0]  w_hs, w_vs;
  logic [14:0] w_ds;
  logic [2:0]  w_row, w_col;
  logic [5:0]  w_pos;
  logic        w_clean, w_single, w_uncorr, w_corr_data;

  hamming_sec_dec #(.N(12), .K(8)) u_dec_h (
    .i_code(r_cw[H_LSB +: 12]), .o_data(w_h_dec), .o_corrected(w_fix[0]), .o_bad_syn(w_bad[0]));
  hamming_sec_dec #(.N(12), .K(8)) u_dec_v (
    .i_code(r_cw[V_LSB +: 12]), .o_data(w_v_dec), .o_corrected(w_fix[1]), .o_bad_syn(w_bad[1]));
  hamming_sec_dec #(.N(12), .K(8)) u_dec_d1 (
    .i_code(r_cw[D1_LSB +: 12]), .o_data(w_d1_dec), .o_corrected(w_fix[2]), .o_bad_syn(w_bad[2]));
  hamming_sec_dec #(.N(11), .K(7)) u_dec_d2 (
    .i_code(r_cw[D2_LSB +: 11]), .o_data(w_d2_dec), .o_corrected(w_fix[3]), .o_bad_syn(w_bad[3]));

  // Recompute row, column and anti-diagonal parity against the received parities.
  always_comb begin
    w_hs = r_h;
    w_vs = r_v;
    w_ds = r_d;
    for (int b = 0; b < DATA_W; b++) begin
      w_hs[b / 8]             = w_hs[b / 8] ^ r_data[b];
      w_vs[b % 8]             = w_vs[b % 8] ^ r_data[b];
      w_ds[diag_idx(6'(b))]   = w_ds[diag_idx(6'(b))] ^ r_data[b];
    end
  end

  // Locate the failing row/column and decide clean / single / uncorrectable.
  always_comb begin
    w_row = 3'd0;
    w_col = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_row = r_hs[i] ? 3'(i) : w_row;
      w_col = r_vs[i] ? 3'(i) : w_col;
    end
    w_pos       = {w_row, w_col};
    w_clean     = (r_hs == 8'd0) && (r_vs == 8'd0) && (r_ds == 15'd0);
    w_single    = $onehot(r_hs) && $onehot(r_vs) && (r_ds == (15'd1 << diag_idx(w_pos)));
    w_uncorr    = r_par_bad || (!w_clean && !w_single);
    w_corr_data = !r_par_bad && w_single;
  end

  // Control FSM with all datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_cw            <= '0;
      r_data          <= '0;
      r_h             <= 8'd0;
      r_v             <= 8'd0;
      r_d             <= 15'd0;
      r_hs            <= 8'd0;
      r_vs            <= 8'd0;
      r_ds            <= 15'd0;
      r_par_corr      <= 1'b0;
      r_par_bad       <= 1'b0;
      r_in_ready      <= 1'b1;
      r_out_valid     <= 1'b0;
      r_data_out      <= '0;
      r_err_corr_data <= 1'b0;
      r_err_corr_par  <= 1'b0;
      r_err_uncorr    <= 1'b0;
      r_err_pos       <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_cw       <= codeword_in;
            r_in_ready <= 1'b0;
            r_state    <= ST_PDEC;
          end
        end
        ST_PDEC: begin
          r_data     <= r_cw[DATA_LSB +: DATA_W];
          r_h        <= w_h_dec;
          r_v        <= w_v_dec;
          r_d        <= {w_d2_dec, w_d1_dec};
          r_par_corr <= |w_fix;
          r_par_bad  <= |w_bad;
          r_state    <= ST_SYND;
        end
        ST_SYND: begin
          r_hs    <= w_hs;
          r_vs    <= w_vs;
          r_ds    <= w_ds;
          r_state <= ST_CORR;
        end
        ST_CORR: begin
          r_data_out      <= w_corr_data ? (r_data ^ (64'd1 << w_pos)) : r_data;
          r_err_corr_data <= w_corr_data;
          r_err_corr_par  <= r_par_corr;
          r_err_uncorr    <= w_uncorr;
          r_err_pos       <= w_corr_data ? w_pos : 6'd0;
          r_out_valid     <= 1'b1;
          r_state         <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  logic [CNT_W-1:0] r_corr_cnt, r_uncorr_cnt;

  // Saturating statistics, counted on each result transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (r_state == ST_OUT && out_ready) begin
      if ((r_err_corr_data || r_err_corr_par) && (r_corr_cnt != {CNT_W{1'b1}})) begin
        r_corr_cnt <= r_corr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (r_err_uncorr && (r_uncorr_cnt != {CNT_W{1'b1}})) begin
        r_uncorr_cnt <= r_uncorr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign corr_cnt   = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;
`endif

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign data_out      = r_data_out;
  assign err_corr_data = r_err_corr_data;
  assign err_corr_par  = r_err_corr_par;
  assign err_uncorr    = r_err_uncorr;
  assign err_pos       = r_err_pos;

endmodule

// File: tb/tb_hamming_product_decoder.sv
// Scoreboard bench for hamming_product_decoder: directed cases plus random
// words with random bit flips, checked against a behavioural model.
`timescale 1ns/1ps
module tb_hamming_product_decoder;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [110:0]  codeword_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   data_out;
  logic          err_corr_data, err_corr_par, err_uncorr;
  logic [5:0]    err_pos;
`ifdef HAMMING_DEC_STATS_EN
  logic [15:0]   corr_cnt, uncorr_cnt;
`endif

  hamming_product_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .codeword_in(codeword_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err_corr_data(err_corr_data), .err_corr_par(err_corr_par),
    .err_uncorr(err_uncorr), .err_pos(err_pos)
`ifdef HAMMING_DEC_STATS_EN
    , .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic        cd;
    logic        cp;
    logic        un;
    logic [5:0]  pos;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: stall
  int   exp_corr = 0;
  int   exp_uncorr = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, want, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Row, column and anti-diagonal parity of a data word.
  function automatic void array_par(input logic [63:0] dt, output logic [7:0] h,
                                    output logic [7:0] v, output logic [14:0] d);
    h = '0; v = '0; d = '0;
    for (int b = 0; b < 64; b++) begin
      if (dt[b]) begin
        h[b / 8] = ~h[b / 8];
        v[b % 8] = ~v[b % 8];
        d[14 - (b / 8 + b % 8)] = ~d[14 - (b / 8 + b % 8)];
      end
    end
  endfunction

  function automatic logic [11:0] henc(input logic [7:0] dv, input int n);
    logic [11:0] x;
    int k;
    int syn;
    x = '0; k = 0; syn = 0;
    for (int p = 1; p <= n; p++) begin
      if ($countones(p) != 1) begin x[p-1] = dv[k]; k++; end
    end
    for (int p = 1; p <= n; p++) if (x[p-1]) syn = syn ^ p;
    for (int j = 0; j < 4; j++) if (((syn >> j) & 1) == 1) x[(1 << j) - 1] = 1'b1;
    return x;
  endfunction

  function automatic void hdec(input logic [11:0] w, input int n, output logic [7:0] dv,
                               output logic fixed, output logic bad);
    logic [11:0] x;
    int syn;
    int k;
    x = w; syn = 0; k = 0; fixed = 1'b0; bad = 1'b0; dv = '0;
    for (int p = 1; p <= n; p++) if (w[p-1]) syn = syn ^ p;
    if (syn > n) bad = 1'b1;
    else if (syn != 0) begin x[syn-1] = ~x[syn-1]; fixed = 1'b1; end
    for (int p = 1; p <= n; p++) begin
      if ($countones(p) != 1) begin dv[k] = x[p-1]; k++; end
    end
  endfunction

  function automatic logic [110:0] encode(input logic [63:0] dt);
    logic [7:0] h, v;
    logic [14:0] d;
    logic [11:0] e2;
    array_par(dt, h, v, d);
    e2 = henc({1'b0, d[14:8]}, 11);
    return {dt, henc(h, 12), henc(v, 12), henc(d[7:0], 12), e2[10:0]};
  endfunction

  function automatic bit consistent(input logic [63:0] dt, input logic [7:0] h,
                                    input logic [7:0] v, input logic [14:0] d);
    logic [7:0] ch, cv;
    logic [14:0] cdg;
    array_par(dt, ch, cv, cdg);
    return (ch == h) && (cv == v) && (cdg == d);
  endfunction

  // Expected result: clean, the unique single data flip that makes all
  // parities consistent, or uncorrectable.
  function automatic exp_t model(input logic [110:0] cw);
    exp_t e;
    logic [63:0] dt;
    logic [7:0] h, v, d1, d2;
    logic [3:0] fx, bd;
    dt = cw[110:47];
    hdec(cw[46:35], 12, h, fx[0], bd[0]);
    hdec(cw[34:23], 12, v, fx[1], bd[1]);
    hdec(cw[22:11], 12, d1, fx[2], bd[2]);
    hdec({1'b0, cw[10:0]}, 11, d2, fx[3], bd[3]);
    e.data = dt; e.cd = 1'b0; e.cp = |fx; e.un = 1'b0; e.pos = 6'd0; e.acc = 0;
    if (|bd) e.un = 1'b1;
    else if (!consistent(dt, h, v, {d2[6:0], d1})) begin
      e.un = 1'b1;
      for (int b = 0; b < 64; b++) begin
        if (consistent(dt ^ (64'd1 << b), h, v, {d2[6:0], d1})) begin
          e.un = 1'b0; e.cd = 1'b1; e.pos = 6'(b); e.data = dt ^ (64'd1 << b);
        end
      end
    end
    return e;
  endfunction

  // ---------------- driver / helpers ----------------
  task automatic send(input logic [110:0] cw);
    int g;
    exp_t e;
    g = 0;
    @(negedge clk);
    codeword_in = cw;
    in_valid = 1'b1;
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, want 1");
      in_valid = 1'b0;
      return;
    end
    e = model(cw);
    e.acc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb_q.size() != 0 || have_cur) && g < 300) begin @(negedge clk); g++; end
    if (sb_q.size() != 0 || have_cur) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d results pending, want 0", sb_q.size());
    end
    @(negedge clk);
  endtask

  task automatic wait_out_valid();
    int g;
    g = 0;
    while (!out_valid && g < 20) begin @(negedge clk); g++; end
    chk("out_valid_wait", out_valid, 1'b1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        have_cur = 1'b0;
        exp_corr = 0;
        exp_uncorr = 0;
        out_ready = 1'b0;
      end else begin
        if (out_valid) begin
          if (!have_cur) begin
            if (sb_q.size() == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL unexpected_result: out_valid=1 with empty scoreboard, want 0");
            end else begin
              cur = sb_q.pop_front();
              have_cur = 1'b1;
              chk("latency", 64'(cyc - cur.acc), 64'd4);
            end
          end
          if (have_cur) begin
            chk("data_out", data_out, cur.data);
            chk("flags{cd,cp,un,pos}", {55'd0, err_corr_data, err_corr_par, err_uncorr, err_pos},
                {55'd0, cur.cd, cur.cp, cur.un, cur.pos});
            chk("in_ready_busy", in_ready, 1'b0);
          end
        end
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b0;
        endcase
        if (out_valid && out_ready && have_cur) begin
          have_cur = 1'b0;
          if ((cur.cd || cur.cp) && exp_corr < 65535) exp_corr++;
          if (cur.un && exp_uncorr < 65535) exp_uncorr++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0]  d0;
    logic [110:0] cw0, cw;
    int k;
    d0 = 64'h5965_3CAA_CF0F_3333;
    cw0 = encode(d0);

    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data_out", data_out, 64'd0);
    chk("rst_flags", {err_corr_data, err_corr_par, err_uncorr, err_pos}, 9'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // 1: clean word
    send(cw0); wait_idle();
    // 2: single data-bit error at bit 27
    cw = cw0; cw[47 + 27] = ~cw[47 + 27];
    send(cw); wait_idle();
    // 3: h_enc bit 5 only
    cw = cw0; cw[35 + 5] = ~cw[35 + 5];
    send(cw); wait_idle();
    // 4: data bits 0 and 9
    cw = cw0; cw[47] = ~cw[47]; cw[56] = ~cw[56];
    send(cw); wait_idle();
`ifdef HAMMING_DEC_STATS_EN
    chk("corr_cnt_t4", corr_cnt, 16'd2);
    chk("uncorr_cnt_t4", uncorr_cnt, 16'd1);
`endif

    // 5: consumer stall for 10 cycles, then release
    ready_mode = 2;
    cw = cw0; cw[47 + 63] = ~cw[47 + 63];
    send(cw);
    wait_out_valid();
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 ready_mode = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (!in_ready && k < 10);
    chk("release_to_in_ready", 64'(k), 64'd2);
    chk("out_valid_after_xfer", out_valid, 1'b0);
    wait_idle();

    // 6: reset in SYND, then a correct re-accept
    send(cw0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_synd_out_valid", out_valid, 1'b0);
    chk("rst_synd_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    cw = cw0; cw[47 + 36] = ~cw[47 + 36];
    send(cw); wait_idle();

    // reset while a corrected result is being held
    ready_mode = 2;
    cw = cw0; cw[47 + 5] = ~cw[47 + 5];
    send(cw);
    wait_out_valid();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_out_out_valid", out_valid, 1'b0);
    chk("rst_out_data_out", data_out, 64'd0);
    chk("rst_out_flags", {err_corr_data, err_corr_par, err_uncorr, err_pos}, 9'd0);
    chk("rst_out_in_ready", in_ready, 1'b1);
`ifdef HAMMING_DEC_STATS_EN
    chk("rst_out_corr_cnt", corr_cnt, 16'd0);
`endif
    @(negedge clk);
    #2 rst = 1'b0;
    ready_mode = 0;

    // random words with 0..3 flipped bits, random consumer backpressure
    ready_mode = 1;
    for (int n = 0; n < 250; n++) begin
      cw = encode({$urandom, $urandom});
      k = $urandom_range(0, 3);
      for (int f = 0; f < k; f++) begin
        if ($urandom_range(0, 1) == 1) cw[47 + $urandom_range(0, 63)] ^= 1'b1;
        else cw[$urandom_range(0, 110)] ^= 1'b1;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(cw);
    end
    wait_idle();
`ifdef HAMMING_DEC_STATS_EN
    chk("corr_cnt_final", corr_cnt, 16'(exp_corr));
    chk("uncorr_cnt_final", uncorr_cnt, 16'(exp_uncorr));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
